// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the instruction-fetch front end: scalar aliases, the fetch
// sequencer state and the decode-boundary record.
package fetch_ctrl_pkg;

  typedef logic [63:0] u64;
  typedef logic [31:0] u32;
  typedef logic        u1;

  localparam u64 BOOT_PC = 64'h8000_0000;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    OUT     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    u1  valid;
    u64 pc;
    u32 instr;
  } fetch_out_t;

endpackage

// File: rtl/fetch_buf.sv
// Output register at the decode boundary: load a fetched word, clear its valid
// bit on consume/squash, otherwise hold.
module fetch_buf
  import fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic [63:0] load_pc,
  input  logic [31:0] load_instr,
  output fetch_out_t  q
);

  fetch_out_t out_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
    end else if (load) begin
      out_q.valid <= 1'b1;
      out_q.pc    <= load_pc;
      out_q.instr <= load_instr;
    end else if (clear) begin
      out_q.valid <= 1'b0;
    end
  end

  assign q = out_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding request at a time, single-entry
// output buffer, redirects while a request is in flight are resolved by discard.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter u64 RESET_PC = BOOT_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_ok,
  input  logic [31:0] iresp_data,
  input  logic        stall,
  input  logic        jump,
  input  logic [63:0] pcsrc,
  output logic [63:0] pc,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr
);

  fetch_state_t state_q, state_d;
  u64           pc_q, pc_d;
  u64           req_addr_q, req_addr_d;
  logic         buf_load, buf_clear;
  fetch_out_t   buf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      req_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    buf_load   = 1'b0;
    buf_clear  = 1'b0;
    case (state_q)
      FETCH: begin
        if (jump) begin
          pc_d = pcsrc;
          // Bus address must stay put until the response, so park it.
          if (!iresp_ok) begin
            req_addr_d = pc_q;
            state_d    = DISCARD;
          end
        end else if (iresp_ok) begin
          buf_load = 1'b1;
          pc_d     = pc_q + 64'd4;
          state_d  = OUT;
        end
      end
      OUT: begin
        if (jump) begin
          buf_clear = 1'b1;
          pc_d      = pcsrc;
          state_d   = FETCH;
        end else if (!stall) begin
          buf_clear = 1'b1;
          state_d   = FETCH;
        end
      end
      DISCARD: begin
        if (jump) pc_d = pcsrc;
        if (iresp_ok) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  fetch_buf u_fetch_buf (
    .clk        (clk),
    .reset      (reset),
    .load       (buf_load),
    .clear      (buf_clear),
    .load_pc    (pc_q),
    .load_instr (iresp_data),
    .q          (buf_q)
  );

  assign ireq_valid = !reset && (state_q != OUT);
  assign ireq_addr  = (state_q == DISCARD) ? req_addr_q : pc_q;
  assign pc         = pc_q;
  assign out_valid  = buf_q.valid;
  assign out_pc     = buf_q.pc;
  assign out_instr  = buf_q.instr;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a request-level reference model and
// hand-computed literal checkpoints.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_ok = 1'b0;
  logic [31:0] iresp_data = '0;
  logic        stall = 1'b0;
  logic        jump = 1'b0;
  logic [63:0] pcsrc = '0;
  logic [63:0] pc;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] RST = 64'h8000_0000;

  fetch_ctrl #(.RESET_PC(RST)) dut (
    .clk        (clk),
    .reset      (reset),
    .ireq_valid (ireq_valid),
    .ireq_addr  (ireq_addr),
    .iresp_ok   (iresp_ok),
    .iresp_data (iresp_data),
    .stall      (stall),
    .jump       (jump),
    .pcsrc      (pcsrc),
    .pc         (pc),
    .out_valid  (out_valid),
    .out_pc     (out_pc),
    .out_instr  (out_instr)
  );

  always #5 clk = ~clk;

  // Model: either the buffer holds an instruction, or a request is on the bus.
  // A request is "dropped" when a redirect hit it before its response arrived.
  logic        m_live = 1'b0;
  logic [63:0] m_pc = '0;
  logic        m_bv = 1'b0;
  logic [63:0] m_bpc = '0;
  logic [31:0] m_binstr = '0;
  logic        m_drop = 1'b0;
  logic [63:0] m_held = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    m_live = 1'b1;
    if (reset) begin
      m_pc = RST; m_bv = 1'b0; m_bpc = '0; m_binstr = '0; m_drop = 1'b0; m_held = '0;
    end else if (m_bv) begin
      if (jump) begin
        m_bv = 1'b0;
        m_pc = pcsrc;
      end else if (!stall) begin
        m_bv = 1'b0;
      end
    end else if (iresp_ok) begin
      if (!m_drop && !jump) begin
        m_bv = 1'b1; m_bpc = m_pc; m_binstr = iresp_data; m_pc = m_pc + 64'd4;
      end else if (jump) begin
        m_pc = pcsrc;
      end
      m_drop = 1'b0;
    end else if (jump) begin
      if (!m_drop) begin
        m_held = m_pc;
        m_drop = 1'b1;
      end
      m_pc = pcsrc;
    end
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      chk("ireq_valid", {63'd0, ireq_valid}, {63'd0, !reset && !m_bv});
      if (ireq_valid) chk("ireq_addr", ireq_addr, m_drop ? m_held : m_pc);
      chk("pc", pc, m_pc);
      chk("out_valid", {63'd0, out_valid}, {63'd0, m_bv});
      chk("out_pc", out_pc, m_bpc);
      chk("out_instr", {32'd0, out_instr}, {32'd0, m_binstr});
    end
  end

  // One clock: apply inputs mid-cycle, clock the edge, then settle.
  task automatic cyc(input logic rst, input logic ok, input logic [31:0] d,
                     input logic st, input logic j, input logic [63:0] tgt);
    @(negedge clk);
    #1;
    reset = rst; iresp_ok = ok; iresp_data = d; stall = st; jump = j; pcsrc = tgt;
    @(posedge clk);
    model_update();
    #2;
  endtask

  task automatic idle(input logic ok, input logic [31:0] d);
    cyc(1'b0, ok, d, 1'b0, 1'b0, '0);
  endtask

  initial begin
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    chk("lit_reset_pc", pc, 64'h8000_0000);
    chk("lit_reset_ov", {63'd0, out_valid}, 64'd0);
    chk("lit_reset_req", {63'd0, ireq_valid}, 64'd0);

    // Zero-wait bus, no stall: one instruction every two cycles.
    idle(1'b1, 32'h1111_0001);
    chk("lit_zw0_pc", out_pc, 64'h8000_0000);
    chk("lit_zw0_in", {32'd0, out_instr}, 64'h1111_0001);
    idle(1'b0, '0);
    chk("lit_zw1_addr", ireq_addr, 64'h8000_0004);
    idle(1'b1, 32'h1111_0002);
    chk("lit_zw1_pc", out_pc, 64'h8000_0004);
    idle(1'b0, '0);
    chk("lit_zw2_addr", ireq_addr, 64'h8000_0008);

    // Latency 3.
    idle(1'b0, '0);
    idle(1'b0, '0);
    chk("lit_lat_addr", ireq_addr, 64'h8000_0008);
    chk("lit_lat_ov", {63'd0, out_valid}, 64'd0);
    idle(1'b1, 32'h2222_0003);
    chk("lit_lat_out", out_pc, 64'h8000_0008);

    // Stall held 4 cycles on the buffered word.
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    chk("lit_stall_ov", {63'd0, out_valid}, 64'd1);
    chk("lit_stall_req", {63'd0, ireq_valid}, 64'd0);
    chk("lit_stall_in", {32'd0, out_instr}, 64'h2222_0003);
    idle(1'b0, '0);
    chk("lit_after_stall", ireq_addr, 64'h8000_000c);

    // Redirect while a request is outstanding.
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 64'h8000_1000);
    chk("lit_disc_addr", ireq_addr, 64'h8000_000c);
    chk("lit_disc_pc", pc, 64'h8000_1000);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 64'h8000_2000);
    idle(1'b1, 32'hdead_beef);
    chk("lit_disc_ov", {63'd0, out_valid}, 64'd0);
    chk("lit_disc_new", ireq_addr, 64'h8000_2000);
    idle(1'b1, 32'h3333_0004);
    chk("lit_disc_out", out_pc, 64'h8000_2000);
    idle(1'b0, '0);

    // Redirect coinciding with the response.
    cyc(1'b0, 1'b1, 32'hbad0_0001, 1'b0, 1'b1, 64'h8000_3000);
    chk("lit_jr_ov", {63'd0, out_valid}, 64'd0);
    chk("lit_jr_addr", ireq_addr, 64'h8000_3000);
    idle(1'b1, 32'h4444_0005);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b1, 64'h8000_4000);
    chk("lit_squash_ov", {63'd0, out_valid}, 64'd0);
    chk("lit_squash_addr", ireq_addr, 64'h8000_4000);

    // Address wrap at the top of the space.
    cyc(1'b0, 1'b1, 32'hbad0_0002, 1'b0, 1'b1, 64'hffff_ffff_ffff_fffc);
    idle(1'b1, 32'h5555_0006);
    chk("lit_wrap_pc", pc, 64'd0);
    idle(1'b0, '0);
    chk("lit_wrap_addr", ireq_addr, 64'd0);

    // Reset while discarding.
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 64'h8000_5000);
    cyc(1'b1, 1'b1, 32'hbad0_0003, 1'b0, 1'b0, '0);
    chk("lit_rst_pc", pc, 64'h8000_0000);
    chk("lit_rst_ov", {63'd0, out_valid}, 64'd0);
    idle(1'b0, '0);
    chk("lit_rst_req", {63'd0, ireq_valid}, 64'd1);
    chk("lit_rst_addr", ireq_addr, 64'h8000_0000);
    idle(1'b1, 32'h6666_0007);
    chk("lit_rst_out", out_pc, 64'h8000_0000);
    idle(1'b0, '0);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the front end. Owns the fetch PC, issues one instruction request at a time on the instruction bus, and buffers the returned word for decode. Honours downstream `stall` and redirects (`jump`/`pcsrc`). A redirect that arrives while a request is outstanding is resolved by completing and discarding that request.

## Interface
Parameters:
- `RESET_PC`, default `64'h8000_0000`: fetch address after reset.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ireq_valid`  out  1  instruction request asserted.
- `ireq_addr`  out  64  request address (u64).
- `iresp_ok`  in  1  response valid; only meaningful while `ireq_valid`=1.
- `iresp_data`  in  32  instruction word, valid with `iresp_ok`.
- `stall`  in  1  decode cannot accept the buffered instruction this cycle.
- `jump`  in  1  redirect request.
- `pcsrc`  in  64  redirect target, valid with `jump`.
- `pc`  out  64  current fetch PC register.
- `out_valid`  out  1  buffered instruction valid to decode.
- `out_pc`  out  64  PC of the buffered instruction.
- `out_instr`  out  32  buffered instruction.

## Operation
- Registers: `state`, `pc`, `req_addr`, `out_valid`, `out_pc`, `out_instr`.
- States:
  - FETCH: `ireq_valid`=1, `ireq_addr`=`pc`.
  - OUT: buffer full, no request.
  - DISCARD: `ireq_valid`=1, `ireq_addr`=`req_addr`; this request's data is dropped.
- FETCH transitions:
  - `jump`=1, `iresp_ok`=1: drop data; `pc`<=`pcsrc`; stay in FETCH.
  - `jump`=1, `iresp_ok`=0: `req_addr`<=`pc`; `pc`<=`pcsrc`; go to DISCARD. The bus address stays stable.
  - `jump`=0, `iresp_ok`=1: `out_pc`<=`pc`; `out_instr`<=`iresp_data`; `out_valid`<=1; `pc`<=`pc`+4 (64-bit modulo wrap); go to OUT.
  - Otherwise: hold.
- OUT transitions:
  - `jump`=1: squash the buffer (`out_valid`<=0); `pc`<=`pcsrc`; go to FETCH. `jump` has priority over `stall`.
  - `stall`=0: instruction consumed this edge; `out_valid`<=0; go to FETCH.
  - `stall`=1: hold all outputs unchanged.
- DISCARD transitions:
  - `jump`=1: `pc`<=`pcsrc` (latest target wins).
  - `iresp_ok`=1: go to FETCH, which requests the current `pc`.
  - Both in the same cycle: take both actions.
- Bus rule: once `ireq_valid` rises, the block holds `ireq_addr` stable until the cycle `iresp_ok`=1. It never withdraws a request except by reset.
- Only one request is outstanding at any time.
- `stall` is ignored outside OUT.
- `pcsrc` is used as given; misalignment is not checked.

## Timing
- Reset values: `state`=FETCH, `pc`=`RESET_PC`, `req_addr`=0, `out_valid`=0, `out_pc`=0, `out_instr`=0.
- `ireq_valid` is forced to 0 while `reset`=1. The first request goes out the cycle after reset deasserts.
- Reset mid-operation abandons any outstanding request and buffered instruction. An `iresp_ok` in the first post-reset cycle is treated as the response to the new request.
- Zero-wait bus (`iresp_ok` in the request cycle N): `out_valid`=1 in cycle N+1.
- With `stall`=0, the next request is issued in N+2. Peak throughput is one instruction per 2 cycles.
- A `jump` sampled at edge N redirects `ireq_addr` to `pcsrc` in cycle N+1. The exception is DISCARD: there the new target is issued in the cycle after the old request's `iresp_ok`.
- `ireq_valid`, `ireq_addr` and all `out_*` are functions of registered state only; there is no combinational path from `stall`, `jump` or `iresp_*`.

## Structure
- Shared pipes package: `fetch_state_t` enum (FETCH, OUT, DISCARD) and a `fetch_out_t` struct (`valid`, `pc`, `instr`) for the decode boundary.
- Common package: `u64`, `u32`, `u1`. `RESET_PC` mirrors the existing `64'h8000_0000` boot constant.
- Sub-module: `fetch_buf`, the output register with load/squash/hold controls. Everything else lives in a single `always_ff` plus a combinational next-state block.

## Test plan
- Reset then zero-wait bus, `stall`=0: requests at 0x80000000, 0x80000004, 0x80000008 on every other cycle; `out_pc`/`out_instr` match.
- Bus latency of 3 cycles: `ireq_addr` stays at 0x80000000 for all 3 cycles; `out_valid` rises one cycle after `iresp_ok`.
- Instruction buffered with `stall`=1 for 4 cycles: `out_*` frozen and `ireq_valid`=0 throughout; next request at `pc`+4 after `stall` drops.
- `jump` to 0x80001000 one cycle after a request issues (latency 3): old address held until `iresp_ok`, its data never appears; next request is to 0x80001000.
- `jump`=1 together with `iresp_ok`=1: no `out_valid`; next cycle requests `pcsrc`. Repeat with `jump` during OUT+`stall`=1: buffer squashed.
- `reset` asserted while in DISCARD: next cycle `pc`=0x80000000, `out_valid`=0, request to 0x80000000.
